// File: rtl/bus_err_pkg.sv
// bus_err_pkg: shared types for the bus error drain
package bus_err_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      FIRE
   } coal_state_e;

endpackage

// File: rtl/bus_err_coalesce.sv
// bus_err_coalesce: interrupt coalescing by pending record count and timeout
module bus_err_coalesce
   import bus_err_pkg::*;
#(
   parameter int CntWidth     = 16,
   parameter int TimeoutWidth = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    pop,
   input  logic [CntWidth-1:0]     thresh,
   input  logic [TimeoutWidth-1:0] timeout,
   input  logic                    ack,
   output logic                    irq
);

   coal_state_e             state;
   logic [CntWidth-1:0]     pending;
   logic [TimeoutWidth-1:0] timer;
   logic [CntWidth-1:0]     thr_eff;
   logic [CntWidth-1:0]     pend_inc;
   logic [TimeoutWidth-1:0] tmr_inc;
   logic                    hit;

   // saturating next values and the fire condition seen from COLLECT
   always_comb begin
      thr_eff  = (thresh == '0) ? CntWidth'(1) : thresh;
      pend_inc = (pop && pending != '1) ? pending + 1'b1 : pending;
      tmr_inc  = (timer != '1) ? timer + 1'b1 : timer;
      hit      = (pend_inc >= thr_eff) || (timeout != '0 && tmr_inc >= timeout);
   end

   // coalescing FSM with registered irq
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         pending <= '0;
         timer   <= '0;
         irq     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (pop) begin
               pending <= CntWidth'(1);
               timer   <= '0;
               state   <= (thr_eff == CntWidth'(1)) ? FIRE : COLLECT;
               irq     <= (thr_eff == CntWidth'(1));
            end
            COLLECT: begin
               pending <= pend_inc;
               timer   <= tmr_inc;
               if (hit) begin
                  state <= FIRE;
                  irq   <= 1'b1;
               end
            end
            FIRE: if (ack) begin
               pending <= CntWidth'(pop);
               timer   <= '0;
               state   <= pop ? COLLECT : IDLE;
               irq     <= 1'b0;
            end else begin
               pending <= pend_inc;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/bus_err_drain.sv
// bus_err_drain: drains the error FIFO into a record stream with count, first capture and irq
module bus_err_drain #(
   parameter int AddrWidth     = 48,
   parameter int MetaDataWidth = 1,
   parameter int ErrBits       = 3,
   parameter int CntWidth      = 16,
   parameter int TimeoutWidth  = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     err_nonempty_i,
   input  logic [ErrBits-1:0]       err_code_i,
   input  logic [AddrWidth-1:0]     err_addr_i,
   input  logic [MetaDataWidth-1:0] err_meta_i,
   output logic                     err_fifo_pop_o,
   output logic                     rec_valid_o,
   input  logic                     rec_ready_i,
   output logic [ErrBits-1:0]       rec_code_o,
   output logic [AddrWidth-1:0]     rec_addr_o,
   output logic [MetaDataWidth-1:0] rec_meta_o,
   input  logic [CntWidth-1:0]      coal_thresh_i,
   input  logic [TimeoutWidth-1:0]  coal_timeout_i,
   output logic                     irq_o,
   input  logic                     irq_ack_i,
   input  logic                     clear_i,
   output logic [CntWidth-1:0]      err_count_o,
   output logic                     first_valid_o,
   output logic [ErrBits-1:0]       first_code_o,
   output logic [AddrWidth-1:0]     first_addr_o,
   output logic [MetaDataWidth-1:0] first_meta_o
);

   typedef struct packed {
      logic [ErrBits-1:0]       code;
      logic [AddrWidth-1:0]     addr;
      logic [MetaDataWidth-1:0] meta;
   } rec_t;

   rec_t head, rec_q, first_q;

   assign head           = '{code: err_code_i, addr: err_addr_i, meta: err_meta_i};
   assign err_fifo_pop_o = err_nonempty_i & (~rec_valid_o | rec_ready_i);
   assign rec_code_o     = rec_q.code;
   assign rec_addr_o     = rec_q.addr;
   assign rec_meta_o     = rec_q.meta;
   assign first_code_o   = first_q.code;
   assign first_addr_o   = first_q.addr;
   assign first_meta_o   = first_q.meta;

   // single-entry output record register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rec_q       <= '0;
         rec_valid_o <= 1'b0;
      end else if (err_fifo_pop_o) begin
         rec_q       <= head;
         rec_valid_o <= 1'b1;
      end else if (rec_ready_i) begin
         rec_valid_o <= 1'b0;
      end
   end

   // saturating error count; clear beats a same-cycle pop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_count_o <= '0;
      else if (clear_i) err_count_o <= '0;
      else if (err_fifo_pop_o && err_count_o != '1) err_count_o <= err_count_o + 1'b1;
   end

   // sticky first-error capture; a record popped during clear is not captured
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         first_q       <= '0;
         first_valid_o <= 1'b0;
      end else if (clear_i) begin
         first_q       <= '0;
         first_valid_o <= 1'b0;
      end else if (err_fifo_pop_o && !first_valid_o) begin
         first_q       <= head;
         first_valid_o <= 1'b1;
      end
   end

   bus_err_coalesce #(
      .CntWidth    (CntWidth),
      .TimeoutWidth(TimeoutWidth)
   ) u_coalesce (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .pop    (err_fifo_pop_o),
      .thresh (coal_thresh_i),
      .timeout(coal_timeout_i),
      .ack    (irq_ack_i),
      .irq    (irq_o)
   );

endmodule

// File: tb/tb_bus_err_drain.sv
// tb_bus_err_drain: directed self-checking bench for bus_err_drain
module tb_bus_err_drain;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        err_nonempty_i;
   logic [2:0]  err_code_i;
   logic [47:0] err_addr_i;
   logic [0:0]  err_meta_i;
   logic        err_fifo_pop_o;
   logic        rec_valid_o;
   logic        rec_ready_i;
   logic [2:0]  rec_code_o;
   logic [47:0] rec_addr_o;
   logic [0:0]  rec_meta_o;
   logic [3:0]  coal_thresh_i;
   logic [15:0] coal_timeout_i;
   logic        irq_o;
   logic        irq_ack_i;
   logic        clear_i;
   logic [3:0]  err_count_o;
   logic        first_valid_o;
   logic [2:0]  first_code_o;
   logic [47:0] first_addr_o;
   logic [0:0]  first_meta_o;

   int total = 0;
   int bad   = 0;
   int pops  = 0;

   bus_err_drain #(.CntWidth(4)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .err_nonempty_i(err_nonempty_i),
      .err_code_i    (err_code_i),
      .err_addr_i    (err_addr_i),
      .err_meta_i    (err_meta_i),
      .err_fifo_pop_o(err_fifo_pop_o),
      .rec_valid_o   (rec_valid_o),
      .rec_ready_i   (rec_ready_i),
      .rec_code_o    (rec_code_o),
      .rec_addr_o    (rec_addr_o),
      .rec_meta_o    (rec_meta_o),
      .coal_thresh_i (coal_thresh_i),
      .coal_timeout_i(coal_timeout_i),
      .irq_o         (irq_o),
      .irq_ack_i     (irq_ack_i),
      .clear_i       (clear_i),
      .err_count_o   (err_count_o),
      .first_valid_o (first_valid_o),
      .first_code_o  (first_code_o),
      .first_addr_o  (first_addr_o),
      .first_meta_o  (first_meta_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_ni = 1'b0;
      err_nonempty_i = 1'b0;
      err_code_i = '0;
      err_addr_i = '0;
      err_meta_i = '0;
      rec_ready_i = 1'b1;
      coal_thresh_i = 4'd1;
      coal_timeout_i = '0;
      irq_ack_i = 1'b0;
      clear_i = 1'b0;
      #1;
      chk("rst_pop", 64'(err_fifo_pop_o), 0);
      chk("rst_valid", 64'(rec_valid_o), 0);
      chk("rst_code", 64'(rec_code_o), 0);
      chk("rst_addr", 64'(rec_addr_o), 0);
      chk("rst_irq", 64'(irq_o), 0);
      chk("rst_count", 64'(err_count_o), 0);
      chk("rst_first_valid", 64'(first_valid_o), 0);
      chk("rst_first_addr", 64'(first_addr_o), 0);
      step();
      step();
      rst_ni = 1'b1;
      step();
      // single record, threshold 1
      err_nonempty_i = 1'b1;
      err_code_i = 3'd3;
      err_addr_i = 48'h1000;
      err_meta_i = 1'b1;
      #1;
      chk("single_pop", 64'(err_fifo_pop_o), 1);
      step();
      err_nonempty_i = 1'b0;
      chk("single_valid", 64'(rec_valid_o), 1);
      chk("single_code", 64'(rec_code_o), 3);
      chk("single_addr", 64'(rec_addr_o), 64'h1000);
      chk("single_meta", 64'(rec_meta_o), 1);
      chk("single_count", 64'(err_count_o), 1);
      chk("single_first_valid", 64'(first_valid_o), 1);
      chk("single_first_code", 64'(first_code_o), 3);
      chk("single_first_addr", 64'(first_addr_o), 64'h1000);
      chk("single_irq", 64'(irq_o), 1);
      irq_ack_i = 1'b1;
      step();
      irq_ack_i = 1'b0;
      chk("single_ack_irq", 64'(irq_o), 0);
      chk("single_drain_valid", 64'(rec_valid_o), 0);
      // backpressure with records A=1, B=2, C=4
      rec_ready_i = 1'b0;
      err_nonempty_i = 1'b1;
      err_code_i = 3'd1;
      err_addr_i = 48'hA0;
      #1;
      chk("bp_first_pop", 64'(err_fifo_pop_o), 1);
      pops = 1;
      step();
      err_code_i = 3'd2;
      err_addr_i = 48'hB0;
      for (int i = 0; i < 5; i++) begin
         pops += int'(err_fifo_pop_o);
         chk("bp_stall_code", 64'(rec_code_o), 1);
         chk("bp_stall_addr", 64'(rec_addr_o), 64'hA0);
         step();
      end
      chk("bp_stall_pops", 64'(pops), 1);
      rec_ready_i = 1'b1;
      #1;
      chk("bp_resume_pop", 64'(err_fifo_pop_o), 1);
      step();
      chk("bp_rec_b", 64'(rec_code_o), 2);
      err_code_i = 3'd4;
      err_addr_i = 48'hC0;
      #1;
      chk("bp_pop_c", 64'(err_fifo_pop_o), 1);
      step();
      err_nonempty_i = 1'b0;
      chk("bp_rec_c", 64'(rec_code_o), 4);
      chk("bp_rec_c_addr", 64'(rec_addr_o), 64'hC0);
      chk("bp_count", 64'(err_count_o), 4);
      chk("bp_first_kept", 64'(first_code_o), 3);
      irq_ack_i = 1'b1;
      step();
      irq_ack_i = 1'b0;
      chk("bp_drained", 64'(rec_valid_o), 0);
      chk("bp_irq_cleared", 64'(irq_o), 0);
      // threshold 4, 4 records 10 cycles apart
      coal_thresh_i = 4'd4;
      for (int i = 0; i < 4; i++) begin
         err_nonempty_i = 1'b1;
         err_code_i = 3'(i);
         step();
         err_nonempty_i = 1'b0;
         chk("thr_irq_after_pop", 64'(irq_o), (i == 3) ? 1 : 0);
         if (i < 3) begin
            for (int j = 0; j < 9; j++) step();
            chk("thr_irq_gap", 64'(irq_o), 0);
         end
      end
      chk("thr_count", 64'(err_count_o), 8);
      irq_ack_i = 1'b1;
      step();
      irq_ack_i = 1'b0;
      chk("thr_ack", 64'(irq_o), 0);
      step();
      chk("thr_idle", 64'(irq_o), 0);
      // timeout 20 with threshold 8
      coal_thresh_i = 4'd8;
      coal_timeout_i = 16'd20;
      err_nonempty_i = 1'b1;
      step();
      err_nonempty_i = 1'b0;
      chk("to_irq_start", 64'(irq_o), 0);
      for (int i = 0; i < 19; i++) step();
      chk("to_irq_before", 64'(irq_o), 0);
      step();
      chk("to_irq_fire", 64'(irq_o), 1);
      // ack together with a pop: back to COLLECT with one pending record
      irq_ack_i = 1'b1;
      err_nonempty_i = 1'b1;
      step();
      irq_ack_i = 1'b0;
      err_nonempty_i = 1'b0;
      chk("ackpop_irq", 64'(irq_o), 0);
      chk("ackpop_count", 64'(err_count_o), 10);
      coal_thresh_i = 4'd2;
      step();
      chk("ackpop_no_fire", 64'(irq_o), 0);
      err_nonempty_i = 1'b1;
      step();
      err_nonempty_i = 1'b0;
      chk("ackpop_second_fires", 64'(irq_o), 1);
      irq_ack_i = 1'b1;
      step();
      irq_ack_i = 1'b0;
      chk("ackpop_ack", 64'(irq_o), 0);
      // clear then saturate the 4-bit counter
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      chk("clr_count", 64'(err_count_o), 0);
      chk("clr_first", 64'(first_valid_o), 0);
      err_nonempty_i = 1'b1;
      for (int i = 0; i < 17; i++) begin
         err_code_i = 3'(i + 1);
         err_addr_i = 48'h2000 + 48'(i);
         step();
      end
      chk("sat_count", 64'(err_count_o), 15);
      chk("sat_first_code", 64'(first_code_o), 1);
      chk("sat_first_addr", 64'(first_addr_o), 64'h2000);
      chk("sat_last_rec", 64'(rec_addr_o), 64'h2010);
      clear_i = 1'b1;
      err_code_i = 3'd5;
      step();
      clear_i = 1'b0;
      chk("clrpop_count", 64'(err_count_o), 0);
      chk("clrpop_first", 64'(first_valid_o), 0);
      chk("clrpop_valid", 64'(rec_valid_o), 1);
      chk("clrpop_code", 64'(rec_code_o), 5);
      err_code_i = 3'd6;
      err_addr_i = 48'h3000;
      step();
      err_nonempty_i = 1'b0;
      rec_ready_i = 1'b0;
      chk("next_first_valid", 64'(first_valid_o), 1);
      chk("next_first_code", 64'(first_code_o), 6);
      chk("next_count", 64'(err_count_o), 1);
      step();
      chk("hold_valid", 64'(rec_valid_o), 1);
      chk("hold_addr", 64'(rec_addr_o), 64'h3000);
      // asynchronous reset mid-operation
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst_valid", 64'(rec_valid_o), 0);
      chk("arst_irq", 64'(irq_o), 0);
      chk("arst_count", 64'(err_count_o), 0);
      chk("arst_first", 64'(first_valid_o), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
